// File: rtl/decode_length.sv
// x86 length decoder: walks a captured 10-byte fetch window one byte per cycle
// and presents prefixes, opcode, ModRM/SIB, displacement and immediate.
// Optional: define DECODE_ADDR16_EN to honour the 67 prefix as 16-bit ModRM addressing.
module decode_length (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  instruction [0:9],
  input  logic        instruction_ready,
  input  logic [31:0] window_address,
  output logic        decode_valid,
  input  logic        decode_ready,
  output logic        prefix_opsize,
  output logic        prefix_addrsize,
  output logic        prefix_lock,
  output logic [1:0]  prefix_rep,
  output logic [2:0]  segment_override,
  output logic [7:0]  opcode,
  output logic        opcode_two_byte,
  output logic [7:0]  modrm,
  output logic [7:0]  sib,
  output logic        modrm_valid,
  output logic        sib_valid,
  output logic [31:0] displacement,
  output logic [2:0]  disp_size,
  output logic [31:0] immediate,
  output logic [2:0]  imm_size,
  output logic [3:0]  instruction_length,
  output logic        decode_error,
  output logic [31:0] program_counter,
  output logic        program_counter_valid,
  output logic [3:0]  debug_state
);

  // Handshake: a result transfers at a rising edge where decode_valid && decode_ready;
  // decode_valid and all fields hold until then, and program_counter_valid pulses
  // for the one cycle that follows the transfer edge.

  typedef enum logic [3:0] {
    IDLE, PREFIX, OPCODE, OPCODE2, MODRM, SIB, DISP, IMM, DONE
  } state_t;

  state_t      state;
  logic [7:0]  win [0:9];
  logic [31:0] base_addr;
  logic [3:0]  p;
  logic [2:0]  disp_cnt;
  logic [2:0]  imm_cnt;

  logic [7:0]  cur;
  logic [2:0]  z_size, op_imm, rm_disp, rm_imm, sib_disp;
  logic        op_modrm, rm_sib, addr16, disp_last, imm_last, consume;
  logic [31:0] disp_next;
  state_t      after;

  assign debug_state = state;

`ifdef DECODE_ADDR16_EN
  assign addr16 = prefix_addrsize;
`else
  assign addr16 = 1'b0;
`endif

  function automatic logic is_prefix(input logic [7:0] b);
    case (b)
      8'h66, 8'h67, 8'hF0, 8'hF2, 8'hF3,
      8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65: is_prefix = 1'b1;
      default:                                 is_prefix = 1'b0;
    endcase
  endfunction

  function automatic logic has_modrm(input logic [7:0] op, input logic two);
    if (two)                    has_modrm = (op[7:4] != 4'h8);
    else if (op[7:6] == 2'b00)  has_modrm = ~op[2];
    else if (op[7:4] == 4'h8)   has_modrm = 1'b1;
    else begin
      case (op)
        8'hC0, 8'hC1, 8'hC6, 8'hC7, 8'hD0, 8'hD1, 8'hD2, 8'hD3,
        8'hF6, 8'hF7, 8'hFE, 8'hFF: has_modrm = 1'b1;
        default:                    has_modrm = 1'b0;
      endcase
    end
  endfunction

  // F6/F7 immediates depend on ModRM.reg and are resolved in the MODRM state.
  function automatic logic [2:0] imm_of(input logic [7:0] op, input logic two,
                                        input logic [2:0] z);
    imm_of = 3'd0;
    if (two) begin
      if (op[7:4] == 4'h8) imm_of = z;
    end else if (op[7:6] == 2'b00) begin
      if (op[2:0] == 3'b100)      imm_of = 3'd1;
      else if (op[2:0] == 3'b101) imm_of = z;
    end else if (op[7:4] == 4'h7)     imm_of = 3'd1;
    else if (op[7:3] == 5'b10110)     imm_of = 3'd1;
    else if (op[7:3] == 5'b10111)     imm_of = z;
    else begin
      case (op)
        8'h68, 8'h81, 8'hC7, 8'hE8, 8'hE9:               imm_of = z;
        8'h6A, 8'h80, 8'h83, 8'hC0, 8'hC1, 8'hC6, 8'hEB: imm_of = 3'd1;
        default:                                         imm_of = 3'd0;
      endcase
    end
  endfunction

  function automatic logic op_known(input logic [7:0] op);
    if (op[7:6] == 2'b00) op_known = (op[2:1] != 2'b11);
    else begin
      case (op[7:4])
        4'h4, 4'h5, 4'h7, 4'h8, 4'h9, 4'hB: op_known = 1'b1;
        default: begin
          case (op)
            8'h68, 8'h6A, 8'hC0, 8'hC1, 8'hC3, 8'hC6, 8'hC7, 8'hCC,
            8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hE8, 8'hE9, 8'hEB, 8'hF4,
            8'hF6, 8'hF7, 8'hFE, 8'hFF: op_known = 1'b1;
            default:                    op_known = 1'b0;
          endcase
        end
      endcase
    end
  endfunction

  always_comb begin
    cur      = (p < 4'd10) ? win[p] : 8'h00;
    z_size   = prefix_opsize ? 3'd2 : 3'd4;
    op_modrm = has_modrm(cur, state == OPCODE2);
    op_imm   = imm_of(cur, state == OPCODE2, z_size);

    rm_sib  = 1'b0;
    rm_disp = 3'd0;
    if (addr16) begin
      if (cur[7:6] == 2'b01)                               rm_disp = 3'd1;
      else if (cur[7:6] == 2'b10)                          rm_disp = 3'd2;
      else if (cur[7:6] == 2'b00 && cur[2:0] == 3'b110)    rm_disp = 3'd2;
    end else begin
      rm_sib = (cur[7:6] != 2'b11) && (cur[2:0] == 3'b100);
      if (cur[7:6] == 2'b01)                               rm_disp = 3'd1;
      else if (cur[7:6] == 2'b10)                          rm_disp = 3'd4;
      else if (cur[7:6] == 2'b00 && cur[2:0] == 3'b101)    rm_disp = 3'd4;
    end

    rm_imm = imm_size;
    if (!opcode_two_byte && (opcode == 8'hF6 || opcode == 8'hF7))
      rm_imm = (cur[5:3] == 3'b000) ? (opcode[0] ? z_size : 3'd1) : 3'd0;
    sib_disp = (modrm[7:6] == 2'b00 && cur[2:0] == 3'b101) ? 3'd4 : disp_size;

    disp_last = (disp_cnt + 3'd1 == disp_size);
    imm_last  = (imm_cnt + 3'd1 == imm_size);

    disp_next = displacement;
    disp_next[{disp_cnt[1:0], 3'b000} +: 8] = cur;
    if (disp_last) begin
      case (disp_size)
        3'd1:    disp_next = {{24{disp_next[7]}}, disp_next[7:0]};
        3'd2:    disp_next = {{16{disp_next[15]}}, disp_next[15:0]};
        default: disp_next = disp_next;
      endcase
    end

    // 'after' is where the walk goes once the byte at p has been consumed.
    consume = 1'b1;
    after   = DONE;
    case (state)
      PREFIX:  begin consume = is_prefix(cur); after = PREFIX; end
      OPCODE:  if (cur == 8'h0F) after = OPCODE2;
               else after = op_modrm ? MODRM : ((op_imm != 3'd0) ? IMM : DONE);
      OPCODE2: after = op_modrm ? MODRM : ((op_imm != 3'd0) ? IMM : DONE);
      MODRM:   after = rm_sib ? SIB : ((rm_disp != 3'd0) ? DISP :
                                      ((rm_imm != 3'd0) ? IMM : DONE));
      SIB:     after = (sib_disp != 3'd0) ? DISP : ((imm_size != 3'd0) ? IMM : DONE);
      DISP:    after = disp_last ? ((imm_size != 3'd0) ? IMM : DONE) : DISP;
      IMM:     after = imm_last ? DONE : IMM;
      default: consume = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      for (int i = 0; i < 10; i++) win[i] <= 8'h00;
      base_addr <= 32'd0;  p <= 4'd0;  disp_cnt <= 3'd0;  imm_cnt <= 3'd0;
      decode_valid <= 1'b0;  program_counter_valid <= 1'b0;  program_counter <= 32'd0;
      prefix_opsize <= 1'b0;  prefix_addrsize <= 1'b0;  prefix_lock <= 1'b0;
      prefix_rep <= 2'd0;  segment_override <= 3'd0;
      opcode <= 8'h00;  opcode_two_byte <= 1'b0;
      modrm <= 8'h00;  sib <= 8'h00;  modrm_valid <= 1'b0;  sib_valid <= 1'b0;
      displacement <= 32'd0;  disp_size <= 3'd0;  immediate <= 32'd0;  imm_size <= 3'd0;
      instruction_length <= 4'd0;  decode_error <= 1'b0;
    end else begin
      program_counter_valid <= 1'b0;
      case (state)
        IDLE: if (instruction_ready) begin
          for (int i = 0; i < 10; i++) win[i] <= instruction[i];
          base_addr <= window_address;  p <= 4'd0;  disp_cnt <= 3'd0;  imm_cnt <= 3'd0;
          prefix_opsize <= 1'b0;  prefix_addrsize <= 1'b0;  prefix_lock <= 1'b0;
          prefix_rep <= 2'd0;  segment_override <= 3'd0;
          opcode <= 8'h00;  opcode_two_byte <= 1'b0;
          modrm <= 8'h00;  sib <= 8'h00;  modrm_valid <= 1'b0;  sib_valid <= 1'b0;
          displacement <= 32'd0;  disp_size <= 3'd0;  immediate <= 32'd0;  imm_size <= 3'd0;
          instruction_length <= 4'd0;  decode_error <= 1'b0;
          state <= PREFIX;
        end
        PREFIX: if (consume) begin
          case (cur)
            8'h66: prefix_opsize <= 1'b1;
            8'h67: begin
              prefix_addrsize <= 1'b1;
`ifndef DECODE_ADDR16_EN
              decode_error <= 1'b1;
`endif
            end
            8'hF0: prefix_lock <= 1'b1;
            8'hF3: prefix_rep <= 2'd1;
            8'hF2: prefix_rep <= 2'd2;
            8'h26: segment_override <= 3'd1;
            8'h2E: segment_override <= 3'd2;
            8'h36: segment_override <= 3'd3;
            8'h3E: segment_override <= 3'd4;
            8'h64: segment_override <= 3'd5;
            default: segment_override <= 3'd6;
          endcase
        end else begin
          state <= OPCODE;
        end
        OPCODE: begin
          opcode <= cur;
          if (cur != 8'h0F) begin
            imm_size <= op_imm;
            if (!op_known(cur)) decode_error <= 1'b1;
          end
        end
        OPCODE2: begin
          opcode <= cur;  opcode_two_byte <= 1'b1;  imm_size <= op_imm;
        end
        MODRM: begin
          modrm <= cur;  modrm_valid <= 1'b1;  disp_size <= rm_disp;  imm_size <= rm_imm;
        end
        SIB: begin
          sib <= cur;  sib_valid <= 1'b1;  disp_size <= sib_disp;
        end
        DISP: begin
          displacement <= disp_next;  disp_cnt <= disp_cnt + 3'd1;
        end
        IMM: begin
          immediate[{imm_cnt[1:0], 3'b000} +: 8] <= cur;  imm_cnt <= imm_cnt + 3'd1;
        end
        DONE: if (decode_ready) begin
          decode_valid <= 1'b0;  program_counter_valid <= 1'b1;  state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Running off the end of the window truncates the instruction at 10 bytes.
      if (consume) begin
        if (after != DONE && p == 4'd9) begin
          decode_error <= 1'b1;  instruction_length <= 4'd10;
          program_counter <= base_addr + 32'd10;
          decode_valid <= 1'b1;  state <= DONE;
        end else begin
          p <= p + 4'd1;
          state <= after;
          if (after == DONE) begin
            decode_valid <= 1'b1;
            instruction_length <= p + 4'd1;
            program_counter <= base_addr + {28'd0, p + 4'd1};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_decode_length.sv
// Directed bench for decode_length: each window's expected decode is queued when
// the window is driven and checked when decode_valid appears.
module tb_decode_length;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  instruction [0:9];
  logic        instruction_ready;
  logic [31:0] window_address;
  logic        decode_valid, decode_ready;
  logic        prefix_opsize, prefix_addrsize, prefix_lock;
  logic [1:0]  prefix_rep;
  logic [2:0]  segment_override;
  logic [7:0]  opcode, modrm, sib;
  logic        opcode_two_byte, modrm_valid, sib_valid;
  logic [31:0] displacement, immediate, program_counter;
  logic [2:0]  disp_size, imm_size;
  logic [3:0]  instruction_length, debug_state;
  logic        decode_error, program_counter_valid;

  typedef struct packed {
    logic [3:0]  len;
    logic        err, opsize, addrsize, lock;
    logic [1:0]  rep;
    logic [2:0]  seg;
    logic [7:0]  opc;
    logic        two;
    logic [7:0]  modrm;
    logic        mv;
    logic [7:0]  sib;
    logic        sv;
    logic [31:0] disp;
    logic [2:0]  dsz;
    logic [31:0] imm;
    logic [2:0]  isz;
    logic        chk_imm;
    logic [31:0] pc;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e;
  logic [7:0] win_tb [0:9];
  int         total = 0;
  int         bad = 0;

  decode_length dut (
    .clock(clock), .reset(reset), .instruction(instruction),
    .instruction_ready(instruction_ready), .window_address(window_address),
    .decode_valid(decode_valid), .decode_ready(decode_ready),
    .prefix_opsize(prefix_opsize), .prefix_addrsize(prefix_addrsize),
    .prefix_lock(prefix_lock), .prefix_rep(prefix_rep),
    .segment_override(segment_override), .opcode(opcode),
    .opcode_two_byte(opcode_two_byte), .modrm(modrm), .sib(sib),
    .modrm_valid(modrm_valid), .sib_valid(sib_valid),
    .displacement(displacement), .disp_size(disp_size),
    .immediate(immediate), .imm_size(imm_size),
    .instruction_length(instruction_length), .decode_error(decode_error),
    .program_counter(program_counter), .program_counter_valid(program_counter_valid),
    .debug_state(debug_state)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t blank();
    exp_t b;
    b = '0;
    b.chk_imm = 1'b1;
    return b;
  endfunction

  // v holds the first n window bytes, byte 0 in the most significant position.
  task automatic set_win(input logic [79:0] v, input int n);
    for (int i = 0; i < 10; i++)
      if (i < n) win_tb[i] = v[8*(n-1-i) +: 8];
      else       win_tb[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic push_exp(input exp_t x, input logic [31:0] addr);
    x.pc = addr + {28'd0, x.len};
    exp_q.push_back(x);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, decode_valid, 0);
    check({tag, "_pcv"}, program_counter_valid, 0);
    check({tag, "_pc"}, program_counter, 0);
    check({tag, "_len"}, instruction_length, 0);
    check({tag, "_err"}, decode_error, 0);
    check({tag, "_opc"}, opcode, 0);
    check({tag, "_modrm"}, {modrm, sib, 6'd0, modrm_valid, sib_valid, 7'd0, opcode_two_byte}, 0);
    check({tag, "_disp"}, displacement, 0);
    check({tag, "_imm"}, immediate, 0);
    check({tag, "_sizes"}, {disp_size, imm_size}, 0);
    check({tag, "_prefix"}, {prefix_opsize, prefix_addrsize, prefix_lock, prefix_rep, segment_override}, 0);
    check({tag, "_state"}, debug_state, 0);
  endtask

  task automatic run_insn(input logic [31:0] addr, input int hold);
    exp_t x;
    int   k;
    @(negedge clock);
    for (int i = 0; i < 10; i++) instruction[i] = win_tb[i];
    window_address = addr;
    instruction_ready = 1'b1;
    decode_ready = (hold == 0);
    @(posedge clock);
    @(negedge clock);
    instruction_ready = 1'b0;
    window_address = $urandom;
    for (int i = 0; i < 10; i++) instruction[i] = 8'($urandom_range(0, 255));
    k = 0;
    while (!decode_valid && k < 40) begin
      @(posedge clock); #1; k++;
    end
    x = exp_q.pop_front();
    check("valid_seen", decode_valid, 1);
    if (!decode_valid) begin decode_ready = 1'b0; return; end
    check("latency", k, 1 + x.len);
    check("length", instruction_length, x.len);
    check("error", decode_error, x.err);
    check("prefixes", {prefix_opsize, prefix_addrsize, prefix_lock, prefix_rep},
          {x.opsize, x.addrsize, x.lock, x.rep});
    check("segment", segment_override, x.seg);
    check("opcode", {opcode_two_byte, opcode}, {x.two, x.opc});
    check("modrm", {modrm_valid, modrm}, {x.mv, x.modrm});
    check("sib", {sib_valid, sib}, {x.sv, x.sib});
    check("disp_size", disp_size, x.dsz);
    check("displacement", displacement, x.disp);
    if (x.chk_imm) begin
      check("imm_size", imm_size, x.isz);
      check("immediate", immediate, x.imm);
    end
    check("pc_done", program_counter, x.pc);
    if (hold > 0) begin
      repeat (hold) begin
        @(posedge clock); #1;
        check("hold_valid", decode_valid, 1);
        check("hold_pcv", program_counter_valid, 0);
        check("hold_imm", immediate, x.imm);
        check("hold_len", instruction_length, x.len);
      end
      decode_ready = 1'b1;
    end
    @(posedge clock); #1;
    check("hs_valid_drop", decode_valid, 0);
    check("hs_pcv", program_counter_valid, 1);
    check("hs_pc", program_counter, x.pc);
    decode_ready = 1'b0;
    @(posedge clock); #1;
    check("pcv_one_cycle", program_counter_valid, 0);
  endtask

  initial begin
    int k;
    logic saw_pcv;
    reset = 1'b1;
    instruction_ready = 1'b0;
    decode_ready = 1'b0;
    window_address = 32'd0;
    for (int i = 0; i < 10; i++) instruction[i] = 8'h00;
    repeat (3) @(posedge clock);
    #1 check_zero("reset");
    @(negedge clock) reset = 1'b0;

    set_win(80'h05_78_56_34_12, 5);
    e = blank(); e.len = 5; e.opc = 8'h05; e.imm = 32'h12345678; e.isz = 4;
    push_exp(e, 32'h1000); run_insn(32'h1000, 0);

    set_win(80'h66_05_34_12, 4);
    e = blank(); e.len = 4; e.opsize = 1; e.opc = 8'h05; e.imm = 32'h1234; e.isz = 2;
    push_exp(e, 32'h2000); run_insn(32'h2000, 0);

    set_win(80'h8B_44_24_F8, 4);
    e = blank(); e.len = 4; e.opc = 8'h8B; e.modrm = 8'h44; e.mv = 1; e.sib = 8'h24; e.sv = 1;
    e.disp = 32'hFFFFFFF8; e.dsz = 1;
    push_exp(e, 32'h3000); run_insn(32'h3000, 0);

    set_win(80'h81_80_78_56_34_12_EF_BE_AD_DE, 10);
    e = blank(); e.len = 10; e.opc = 8'h81; e.modrm = 8'h80; e.mv = 1;
    e.disp = 32'h12345678; e.dsz = 4; e.imm = 32'hDEADBEEF; e.isz = 4;
    push_exp(e, 32'h4000); run_insn(32'h4000, 0);

    set_win(80'h3E_81_80_78_56_34_12_EF_BE_AD, 10);
    e = blank(); e.len = 10; e.err = 1; e.seg = 4; e.opc = 8'h81; e.modrm = 8'h80; e.mv = 1;
    e.disp = 32'h12345678; e.dsz = 4; e.chk_imm = 1'b0;
    push_exp(e, 32'hFFFF_FFFA); run_insn(32'hFFFF_FFFA, 0);

    set_win(80'hEB_FE, 2);
    e = blank(); e.len = 2; e.opc = 8'hEB; e.imm = 32'hFE; e.isz = 1;
    push_exp(e, 32'h5000); run_insn(32'h5000, 0);

    set_win(80'h0F_84_10_00_00_00, 6);
    e = blank(); e.len = 6; e.two = 1; e.opc = 8'h84; e.imm = 32'h10; e.isz = 4;
    push_exp(e, 32'h6000); run_insn(32'h6000, 3);

    set_win(80'hF7_C0_01_00_00_00, 6);
    e = blank(); e.len = 6; e.opc = 8'hF7; e.modrm = 8'hC0; e.mv = 1; e.imm = 32'h1; e.isz = 4;
    push_exp(e, 32'h7000); run_insn(32'h7000, 0);

    set_win(80'hF2_F0_65_90, 4);
    e = blank(); e.len = 4; e.rep = 2; e.lock = 1; e.seg = 6; e.opc = 8'h90;
    push_exp(e, 32'h8000); run_insn(32'h8000, 1);

    set_win(80'h06, 1);
    e = blank(); e.len = 1; e.err = 1; e.opc = 8'h06;
    push_exp(e, 32'h9000); run_insn(32'h9000, 0);

    // 16-bit addressing: mod=01 rm=110 gives disp8; 32-bit rules agree on length.
    set_win(80'h67_8B_46_02, 4);
    e = blank(); e.len = 4; e.addrsize = 1; e.opc = 8'h8B; e.modrm = 8'h46; e.mv = 1;
    e.disp = 32'h2; e.dsz = 1;
`ifndef DECODE_ADDR16_EN
    e.err = 1;
`endif
    push_exp(e, 32'hA000); run_insn(32'hA000, 0);

    // Reset while walking the displacement.
    set_win(80'h8B_80_11_22_33_44, 6);
    @(negedge clock);
    for (int i = 0; i < 10; i++) instruction[i] = win_tb[i];
    window_address = 32'hB000;
    instruction_ready = 1'b1;
    decode_ready = 1'b1;
    @(posedge clock);
    @(negedge clock) instruction_ready = 1'b0;
    k = 0;
    while (debug_state != 4'd6 && k < 20) begin
      @(posedge clock); #1; k++;
    end
    check("reached_disp", debug_state, 4'd6);
    #2 reset = 1'b1;
    #1 check_zero("mid_reset");
    @(negedge clock) reset = 1'b0;
    saw_pcv = 1'b0;
    repeat (15) begin
      @(posedge clock); #1;
      if (program_counter_valid || decode_valid) saw_pcv = 1'b1;
    end
    check("no_pcv_after_abort", saw_pcv, 0);
    decode_ready = 1'b0;

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
